// File: rtl/bist_sequencer.sv
// bist_sequencer: BIST controller sequencing TPG/ORA around the CUT and checking the final signature.
// Optional mid-run signature checkpoint enabled by defining BIST_CHECKPOINT_EN.
module bist_sequencer #(
  parameter int SIG_W = 49,
  parameter int NUM_PATTERNS = 2000,
  parameter int FLUSH_CYCLES = 4,
  parameter logic [SIG_W-1:0] GOLDEN_SIG = '0
`ifdef BIST_CHECKPOINT_EN
  ,
  parameter int CHK_PATTERN = 1000,
  parameter logic [SIG_W-1:0] CHK_SIG = '0
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic bistmode,
  input  logic [SIG_W-1:0] ora_sig,
  output logic tpg_load,
  output logic tpg_en,
  output logic ora_clr,
  output logic ora_en,
  output logic cut_sel,
  output logic bistdone,
  output logic bistpass
);
  localparam int CW = $clog2(NUM_PATTERNS + 1);
  localparam int FW = FLUSH_CYCLES > 1 ? $clog2(FLUSH_CYCLES) : 1;
  typedef enum logic [2:0] {IDLE, SEED, RUN, FLUSH, CHECK, DONE} state_t;
  state_t state, state_d;
  logic [CW-1:0] count;
  logic [FW-1:0] fcnt;
  logic pass, fail;
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = SEED;
      SEED:    state_d = RUN;
      RUN:     state_d = count != CW'(NUM_PATTERNS - 1) ? RUN : FLUSH_CYCLES == 0 ? CHECK : FLUSH;
      FLUSH:   state_d = fcnt == FW'(FLUSH_CYCLES - 1) ? CHECK : FLUSH;
      CHECK:   state_d = DONE;
      default: state_d = DONE;
    endcase
    if (!bistmode) state_d = IDLE;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      count <= '0;
      fcnt <= '0;
      pass <= 1'b0;
    end else begin
      state <= state_d;
      count <= state == RUN && state_d == RUN ? count + 1'b1 : '0;
      fcnt <= state == FLUSH && state_d == FLUSH ? fcnt + 1'b1 : '0;
      pass <= bistmode && (state == CHECK ? ora_sig == GOLDEN_SIG && !fail : state == DONE && pass);
    end
`ifdef BIST_CHECKPOINT_EN
  logic fail_q;
  always_ff @(posedge clk)
    if (rst || state == SEED) fail_q <= 1'b0;
    else if (state == RUN && count == CW'(CHK_PATTERN) && ora_sig != CHK_SIG) fail_q <= 1'b1;
  assign fail = fail_q;
`else
  assign fail = 1'b0;
`endif
  assign tpg_load = state == SEED;
  assign ora_clr = state == SEED;
  assign tpg_en = state == RUN;
  assign ora_en = state == RUN || state == FLUSH;
  assign cut_sel = state inside {SEED, RUN, FLUSH, CHECK};
  assign bistdone = state == DONE;
  assign bistpass = pass;
endmodule

// File: tb/tb_bist_sequencer.sv
// tb_bist_sequencer: scoreboard bench for bist_sequencer (8 patterns, flush 2, plus a flush-0 instance).
module tb_bist_sequencer;
  localparam int W = 49;
  localparam logic [W-1:0] G = 49'h1_2345;
  logic clk = 1'b0, rst = 1'b1, bistmode = 1'b0;
  logic [W-1:0] sig = G;
  logic tpg_load, tpg_en, ora_clr, ora_en, cut_sel, bistdone, bistpass;
  logic z_load, z_tpg, z_clr, z_ora, z_cut, z_done, z_pass;
  int pass_n = 0, tot = 0;
  typedef struct {int done_edge; logic pass; int tpg; int ora;} exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  bist_sequencer #(.SIG_W(W), .NUM_PATTERNS(8), .FLUSH_CYCLES(2), .GOLDEN_SIG(G)
`ifdef BIST_CHECKPOINT_EN
    , .CHK_PATTERN(3), .CHK_SIG(G)
`endif
  ) dut (.clk(clk), .rst(rst), .bistmode(bistmode), .ora_sig(sig), .tpg_load(tpg_load),
         .tpg_en(tpg_en), .ora_clr(ora_clr), .ora_en(ora_en), .cut_sel(cut_sel),
         .bistdone(bistdone), .bistpass(bistpass));
  bist_sequencer #(.SIG_W(W), .NUM_PATTERNS(8), .FLUSH_CYCLES(0), .GOLDEN_SIG(G)) dut0 (
    .clk(clk), .rst(rst), .bistmode(bistmode), .ora_sig(sig), .tpg_load(z_load),
    .tpg_en(z_tpg), .ora_clr(z_clr), .ora_en(z_ora), .cut_sel(z_cut),
    .bistdone(z_done), .bistpass(z_pass));
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic run_bist(input string nm, input logic [W-1:0] s, input logic ep, input logic chk_bad);
    exp_t e;
    int nt = 0, no = 0, nl = 0, nc = 0, zo = 0, z_edge = 0;
    logic got = 1'b0;
    sig = s;
    q.push_back('{13, ep, 8, 10});
    rst = 1'b1; bistmode = 1'b1;
    tick;
    tot++; if (bistdone !== 1'b0) $display("FAIL %s_done_in_rst got=%b want=0", nm, bistdone); else pass_n++;
    rst = 1'b0;
    for (int k = 1; k <= 40 && !got; k++) begin
      tick;
      if (chk_bad && k == 5) sig = s ^ 49'h1;
      if (chk_bad && k == 6) sig = s;
      nt += int'(tpg_en); no += int'(ora_en); nl += int'(tpg_load); nc += int'(ora_clr); zo += int'(z_ora);
      if (z_done && z_edge == 0) z_edge = k;
      if (bistdone) begin
        got = 1'b1;
        e = q.pop_front();
        tot++; if (k !== e.done_edge) $display("FAIL %s_done_edge got=%0d want=%0d", nm, k, e.done_edge); else pass_n++;
        tot++; if (bistpass !== e.pass) $display("FAIL %s_pass got=%b want=%b", nm, bistpass, e.pass); else pass_n++;
        tot++; if (nt !== e.tpg) $display("FAIL %s_tpg_en_cycles got=%0d want=%0d", nm, nt, e.tpg); else pass_n++;
        tot++; if (no !== e.ora) $display("FAIL %s_ora_en_cycles got=%0d want=%0d", nm, no, e.ora); else pass_n++;
        tot++; if ({nl, nc} !== {32'd1, 32'd1}) $display("FAIL %s_seed_pulses got=%0d/%0d want=1/1", nm, nl, nc); else pass_n++;
        tot++; if ({z_edge, zo} !== {32'd11, 32'd8}) $display("FAIL %s_flush0 got=edge%0d/ora%0d want=edge11/ora8", nm, z_edge, zo); else pass_n++;
      end
    end
    if (!got) begin tot++; $display("FAIL %s_timeout got=no_bistdone want=bistdone", nm); end
    for (int k = 0; k < 3; k++) tick;
    tot++; if ({bistdone, bistpass, cut_sel} !== {1'b1, ep, 1'b0}) $display("FAIL %s_hold got=%b want=%b", nm, {bistdone, bistpass, cut_sel}, {1'b1, ep, 1'b0}); else pass_n++;
  endtask
  task automatic test_reset;
    rst = 1'b1; bistmode = 1'b0;
    tick; tick;
    tot++; if ({tpg_load, tpg_en, ora_clr, ora_en, cut_sel, bistdone, bistpass} !== 7'b0) $display("FAIL reset got=%b want=0000000", {tpg_load, tpg_en, ora_clr, ora_en, cut_sel, bistdone, bistpass}); else pass_n++;
  endtask
  task automatic test_match;
    run_bist("match", G, 1'b1, 1'b0);
  endtask
  task automatic test_mismatch;
    run_bist("mismatch", 49'h1_2344, 1'b0, 1'b0);
  endtask
  task automatic test_back_to_back;
    run_bist("b2b_first", G, 1'b1, 1'b0);
    run_bist("b2b_second", G, 1'b1, 1'b0);
  endtask
  task automatic test_abort;
    int seen = 0;
    rst = 1'b1; bistmode = 1'b1; sig = G;
    tick; rst = 1'b0;
    for (int k = 1; k <= 6; k++) tick;
    bistmode = 1'b0;
    tick;
    tot++; if ({cut_sel, tpg_en, ora_en} !== 3'b0) $display("FAIL abort_idle got=%b want=000", {cut_sel, tpg_en, ora_en}); else pass_n++;
    for (int k = 0; k < 15; k++) begin tick; seen += int'(bistdone); end
    tot++; if (seen !== 0) $display("FAIL abort_no_done got=%0d want=0", seen); else pass_n++;
    rst = 1'b1; bistmode = 1'b1;
    tick; rst = 1'b0;
    for (int k = 1; k <= 11; k++) tick;
    tot++; if (ora_en !== 1'b1 || tpg_en !== 1'b0) $display("FAIL flush_state got=%b%b want=10", ora_en, tpg_en); else pass_n++;
    rst = 1'b1;
    tick;
    tot++; if ({tpg_load, tpg_en, ora_clr, ora_en, cut_sel, bistdone, bistpass} !== 7'b0) $display("FAIL rst_in_flush got=%b want=0000000", {tpg_load, tpg_en, ora_clr, ora_en, cut_sel, bistdone, bistpass}); else pass_n++;
  endtask
  task automatic test_system_mode;
    int bad = 0;
    bistmode = 1'b0;
    for (int k = 0; k < 50; k++) begin
      rst = (k % 3) == 0;
      tick;
      if ({tpg_load, tpg_en, ora_clr, ora_en, cut_sel, bistdone, bistpass, z_load, z_tpg, z_clr, z_ora, z_cut, z_done, z_pass} !== 14'b0) bad++;
    end
    rst = 1'b0;
    tot++; if (bad !== 0) $display("FAIL system_mode got=%0d_bad_cycles want=0", bad); else pass_n++;
  endtask
  task automatic test_checkpoint;
    logic ep;
`ifdef BIST_CHECKPOINT_EN
    ep = 1'b0;
`else
    ep = 1'b1;
`endif
    run_bist("chk_bad", G, ep, 1'b1);
    run_bist("chk_good", G, 1'b1, 1'b0);
  endtask
  initial begin
    test_reset;
    test_match;
    test_mismatch;
    test_back_to_back;
    test_abort;
    test_system_mode;
    test_checkpoint;
    $display("%0d/%0d checks passed", pass_n, tot);
    $finish;
  end
endmodule
